// File: rtl/ghash_pkg.sv
// Shared GF(2^128) types and constants for the GHASH H-power generator.
// GHASH_HPOW_H3_EN adds the MUL3 state that produces H^3.
package ghash_pkg;

   typedef logic [127:0] gf128_t;

   localparam int     GF128_BITS = 128;
   // Reduction constant in GCM bit order: x^0 at bit 127.
   localparam gf128_t GF128_R    = {8'hE1, 120'd0};

   typedef enum logic [2:0] {
      IDLE,
      SQ2,
      SQ4,
`ifdef GHASH_HPOW_H3_EN
      MUL3,
`endif
      DONE
   } hpow_state_t;

endpackage

// File: rtl/ghash_hpow_gen_if.sv
// Interface between the H-power generator and its host/consumer.
// GHASH_HPOW_H3_EN adds the h3 signal.
interface ghash_hpow_gen_if import ghash_pkg::*; ();

   // h_load is a one-cycle pulse with no back-pressure: it is always accepted
   // and restarts generation. h1/h2/h4 (and h3) may only be consumed while
   // h_valid is 1; busy and h_valid are never 1 together.
   gf128_t      h_i;
   logic        h_load;
   gf128_t      h1;
   gf128_t      h2;
   gf128_t      h4;
`ifdef GHASH_HPOW_H3_EN
   gf128_t      h3;
`endif
   logic        h_valid;
   logic        busy;
   hpow_state_t state;

   modport master (
      output h_i, h_load,
      input  h1, h2, h4,
`ifdef GHASH_HPOW_H3_EN
      input  h3,
`endif
      input  h_valid, busy, state
   );

   modport slave (
      input  h_i, h_load,
      output h1, h2, h4,
`ifdef GHASH_HPOW_H3_EN
      output h3,
`endif
      output h_valid, busy, state
   );

endinterface

// File: rtl/gf128_mul_serial.sv
// Bit-serial GCM multiply: 128 cycles after start; done and product are
// combinational on the final cycle so the caller can register the result.
module gf128_mul_serial import ghash_pkg::*; (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  gf128_t a,
   input  gf128_t b,
   output logic   done,
   output gf128_t product
);

   gf128_t     x_q, x_d;
   gf128_t     z_q, z_d;
   gf128_t     v_q, v_d;
   logic [6:0] cnt_q, cnt_d;
   logic       run_q, run_d;
   gf128_t     z_step;

   always_comb begin
      z_step  = x_q[127] ? (z_q ^ v_q) : z_q;
      product = z_step;
      done    = run_q && (cnt_q == 7'd127);
      x_d     = x_q;
      z_d     = z_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      // A new start abandons any multiply in flight.
      if (start) begin
         x_d   = a;
         v_d   = b;
         z_d   = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         x_d   = {x_q[126:0], 1'b0};
         z_d   = z_step;
         v_d   = (v_q >> 1) ^ (v_q[0] ? GF128_R : '0);
         cnt_d = cnt_q + 7'd1;
         if (done) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         z_q   <= '0;
         v_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         z_q   <= z_d;
         v_q   <= v_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/ghash_hpow_gen.sv
// Generates H, H^2, H^4 (and H^3 when GHASH_HPOW_H3_EN is defined) from the
// hash subkey using one shared serial multiplier.
module ghash_hpow_gen import ghash_pkg::*; #(
   parameter int MUL_CYCLES = 128
) (
   input logic              clk,
   input logic              rst,
   ghash_hpow_gen_if.slave  bus
);

   if (MUL_CYCLES != GF128_BITS) begin : g_bad_mul_cycles
      $error("ghash_hpow_gen: MUL_CYCLES must be 128");
   end

   hpow_state_t state_q, state_d;
   gf128_t      h1_q, h2_q, h4_q;
   logic        mul_start, mul_done;
   gf128_t      mul_a, mul_b, mul_prod;
`ifdef GHASH_HPOW_H3_EN
   gf128_t      h3_q;
`endif

   gf128_mul_serial u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (mul_a),
      .b       (mul_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.h_load) begin
         state_d = SQ2;
      end else begin
         case (state_q)
            SQ2:     if (mul_done) state_d = SQ4;
`ifdef GHASH_HPOW_H3_EN
            SQ4:     if (mul_done) state_d = MUL3;
            MUL3:    if (mul_done) state_d = DONE;
`else
            SQ4:     if (mul_done) state_d = DONE;
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bus.busy    = 1'b0;
      bus.h_valid = 1'b0;
      bus.state   = state_q;
      case (state_q)
         SQ2, SQ4:  bus.busy    = 1'b1;
`ifdef GHASH_HPOW_H3_EN
         MUL3:      bus.busy    = 1'b1;
`endif
         DONE:      bus.h_valid = 1'b1;
         default:   bus.busy    = 1'b0;
      endcase
   end

   // Each completed product immediately seeds the next multiply.
   always_comb begin
      mul_start = 1'b0;
      mul_a     = bus.h_i;
      mul_b     = bus.h_i;
      if (bus.h_load) begin
         mul_start = 1'b1;
      end else if (mul_done) begin
         case (state_q)
            SQ2: begin
               mul_start = 1'b1;
               mul_a     = mul_prod;
               mul_b     = mul_prod;
            end
`ifdef GHASH_HPOW_H3_EN
            SQ4: begin
               mul_start = 1'b1;
               mul_a     = h2_q;
               mul_b     = h1_q;
            end
`endif
            default: mul_start = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h1_q <= '0;
         h2_q <= '0;
         h4_q <= '0;
      end else if (bus.h_load) begin
         h1_q <= bus.h_i;
      end else if (mul_done) begin
         if (state_q == SQ2) h2_q <= mul_prod;
         if (state_q == SQ4) h4_q <= mul_prod;
      end
   end

`ifdef GHASH_HPOW_H3_EN
   always_ff @(posedge clk) begin
      if (rst)                                         h3_q <= '0;
      else if (!bus.h_load && mul_done && state_q == MUL3) h3_q <= mul_prod;
   end
   assign bus.h3 = h3_q;
`endif

   assign bus.h1 = h1_q;
   assign bus.h2 = h2_q;
   assign bus.h4 = h4_q;

endmodule

// File: tb/tb_ghash_hpow_gen.sv
// Directed bench for ghash_hpow_gen; expected powers come from an independent
// carry-less multiply/reduce model. Honours GHASH_HPOW_H3_EN.
module tb_ghash_hpow_gen;
   import ghash_pkg::*;

`ifdef GHASH_HPOW_H3_EN
   localparam int LAT = 385;
`else
   localparam int LAT = 257;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   // {h1, h2, h3, h4}
   logic [511:0] exp_q[$];

   ghash_hpow_gen_if bus ();

   ghash_hpow_gen #(.MUL_CYCLES(128)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic gf128_t rev128(input gf128_t v);
      gf128_t r;
      for (int i = 0; i < 128; i++) r[i] = v[127-i];
      return r;
   endfunction

   // Normal-order polynomial product, then fold x^128 = x^7 + x^2 + x + 1.
   function automatic gf128_t gf_mul_ref(input gf128_t a, input gf128_t b);
      gf128_t       ar, br;
      logic [255:0] p;
      ar = rev128(a);
      br = rev128(b);
      p  = '0;
      for (int i = 0; i < 128; i++)
         if (ar[i]) p = p ^ ({128'd0, br} << i);
      for (int i = 255; i >= 128; i--) begin
         if (p[i]) begin
            p[i]     = 1'b0;
            p[i-121] = ~p[i-121];
            p[i-126] = ~p[i-126];
            p[i-127] = ~p[i-127];
            p[i-128] = ~p[i-128];
         end
      end
      return rev128(p[127:0]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_h1"}, bus.h1, '0);
      chk({tag, "_h2"}, bus.h2, '0);
      chk({tag, "_h4"}, bus.h4, '0);
`ifdef GHASH_HPOW_H3_EN
      chk({tag, "_h3"}, bus.h3, '0);
`endif
      chk({tag, "_valid"}, {127'd0, bus.h_valid}, 128'd0);
      chk({tag, "_busy"},  {127'd0, bus.busy},    128'd0);
      chk({tag, "_state"}, {125'd0, bus.state},   {125'd0, IDLE});
   endtask

   task automatic do_load(input gf128_t v);
      gf128_t e2, e4;
      e2 = gf_mul_ref(v, v);
      e4 = gf_mul_ref(e2, e2);
      exp_q.push_back({v, e2, gf_mul_ref(e2, v), e4});
      bus.h_i    = v;
      bus.h_load = 1'b1;
      tick();
      bus.h_load = 1'b0;
      bus.h_i    = {$urandom, $urandom, $urandom, $urandom};
      chk("load_h1",    bus.h1, v);
      chk("load_busy",  {127'd0, bus.busy},    128'd1);
      chk("load_valid", {127'd0, bus.h_valid}, 128'd0);
   endtask

   // Entered in cycle T+1; h_valid must first appear in cycle T+LAT.
   task automatic wait_valid(input string tag);
      int           n;
      logic         busy_ok;
      logic [511:0] e;
      n       = 1;
      busy_ok = 1'b1;
      while (bus.h_valid !== 1'b1 && n < LAT + 50) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         tick();
         n++;
      end
      chk({tag, "_latency"},   n, LAT);
      chk({tag, "_busy_run"},  {127'd0, busy_ok},  128'd1);
      chk({tag, "_busy_done"}, {127'd0, bus.busy}, 128'd0);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 128'd0, 128'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_h1"}, bus.h1, e[511:384]);
         chk({tag, "_h2"}, bus.h2, e[383:256]);
`ifdef GHASH_HPOW_H3_EN
         chk({tag, "_h3"}, bus.h3, e[255:128]);
`endif
         chk({tag, "_h4"}, bus.h4, e[127:0]);
      end
   endtask

   localparam gf128_t ONE  = {1'b1, 127'd0};
   localparam gf128_t X1   = {2'b01, 126'd0};
   localparam gf128_t X32  = 128'h00000000_80000000_00000000_00000000;

   initial begin
      gf128_t held_h4;
      logic   flag;

      bus.h_i    = '0;
      bus.h_load = 1'b0;

      // Reset and idle behaviour.
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk_reset_vals("reset");
      repeat (5) tick();
      chk_reset_vals("idle");

      // Reset beats a coincident load.
      rst        = 1'b1;
      bus.h_i    = ONE;
      bus.h_load = 1'b1;
      tick();
      rst        = 1'b0;
      bus.h_load = 1'b0;
      chk_reset_vals("rst_vs_load");

      // Unity, then hold in DONE.
      do_load(ONE);
      wait_valid("unity");
      chk("unity_h2_const", bus.h2, ONE);
      chk("unity_h4_const", bus.h4, ONE);
      repeat (20) tick();
      chk("hold_valid", {127'd0, bus.h_valid}, 128'd1);
      chk("hold_h4",    bus.h4, ONE);

      do_load(X1);
      wait_valid("x");
      chk("x_h2_const", bus.h2, 128'h20000000_00000000_00000000_00000000);
      chk("x_h4_const", bus.h4, 128'h08000000_00000000_00000000_00000000);
`ifdef GHASH_HPOW_H3_EN
      chk("x_h3_const", bus.h3, 128'h10000000_00000000_00000000_00000000);
`endif

      do_load(X32);
      wait_valid("x32");
      chk("x32_h2_const", bus.h2, 128'h00000000_00000000_80000000_00000000);
      chk("x32_h4_const", bus.h4, 128'hE1000000_00000000_00000000_00000000);

      do_load('0);
      wait_valid("zero");

      // Reload at T+100 aborts the x^32 run.
      do_load(X32);
      flag = 1'b1;
      repeat (99) begin
         if (bus.h_valid !== 1'b0) flag = 1'b0;
         tick();
      end
      chk("abort_no_valid", {127'd0, flag}, 128'd1);
      void'(exp_q.pop_back());
      do_load(ONE);
      wait_valid("abort");

      // Reset at T+150, in the middle of the H^4 multiply.
      do_load(X32);
      repeat (149) tick();
      held_h4 = bus.h4;
      chk("mid_sq4_h4_stable", held_h4, ONE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(exp_q.pop_back());
      chk_reset_vals("mid_rst");
      tick();
      chk_reset_vals("after_rst");

      do_load({$urandom, $urandom, $urandom, $urandom});
      wait_valid("rand0");
      do_load({$urandom, $urandom, $urandom, $urandom});
      wait_valid("rand1");

      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ghash_hpow_gen.md
GHASH_HPOW_GEN -- requirements
Module: ghash_hpow_gen

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 128, fixed GF multiply latency; other values SHALL be illegal (elaboration error).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port h_i  input  128  hash subkey H = E(K, 0^128), GCM bit order (bit 127 = x^0).
REQ-005 SHALL have port h_load  input  1  one-cycle pulse; samples h_i and starts generation.
REQ-006 SHALL have port h1  output  128  registered copy of H.
REQ-007 SHALL have port h2  output  128  H^2 in GF(2^128).
REQ-008 SHALL have port h4  output  128  H^4 in GF(2^128).
REQ-009 SHALL have port h_valid  output  1  h1/h2/h4 (and h3 if built) mutually consistent and final.
REQ-010 SHALL have port busy  output  1  generation in progress.

Function
REQ-011 Field multiply SHALL be GCM bit-reflected, poly x^128+x^7+x^2+x+1, R = 0xE1 followed by 120 zero bits.
REQ-012 Multiply SHALL be bit-serial: Z=0, V=Y; per cycle i=0..127 take X bit (127-i); if 1 then Z^=V; V = V>>1, XOR R if shifted-out bit was 1.
REQ-013 FSM states SHALL be IDLE, SQ2, SQ4, DONE (plus MUL3 per REQ-024).
REQ-014 h_load in cycle T SHALL capture h_i into h1, clear h_valid, enter SQ2 at T+1.
REQ-015 SQ2 SHALL compute h1*h1 over cycles T+1..T+128; h2 updates at T+129; state becomes SQ4.
REQ-016 SQ4 SHALL compute h2*h2 over T+129..T+256; h4 updates at T+257; state becomes DONE with h_valid=1 at T+257.
REQ-017 busy SHALL be 1 from T+1 until h_valid rises, 0 otherwise; busy and h_valid SHALL never be 1 together.
REQ-018 DONE SHALL hold all outputs and h_valid=1 until the next h_load or rst.
REQ-019 h_load during SQ2/SQ4/DONE SHALL abort the current computation, reload h1, restart at SQ2 (same timing as REQ-014); no stale h2/h4 SHALL be flagged valid.
REQ-020 h2/h4 SHALL only change at multiply completion; partial products SHALL never appear on outputs.
REQ-021 h_load and rst in the same cycle: rst SHALL win.

Reset
REQ-022 rst SHALL force state IDLE, h1=h2=h4=0 (h3=0), h_valid=0, busy=0, multiplier counter/accumulator cleared, effective the next edge, including mid-operation.
REQ-023 After reset, outputs SHALL stay at reset values until h_load.

Configuration
REQ-024 Macro GHASH_HPOW_H3_EN: when defined, adds output port h3 (128) and state MUL3 after SQ4 computing h2*h1 over T+257..T+384; h_valid rises at T+385, h4 still updates at T+257.
REQ-025 Without GHASH_HPOW_H3_EN: no h3 port, no MUL3 state, h_valid at T+257.

Structure
REQ-026 Shared package ghash_pkg SHALL hold GF128_R constant (0xE1<<120), gf128_t (128-bit) typedef, hpow_state_t enum.
REQ-027 Serial multiply SHALL be sub-module gf128_mul_serial (start, a, b, done pulse, product); ghash_hpow_gen owns FSM and operand muxing.
REQ-028 Outputs h1/h2/h4 SHALL connect directly to consumer h1/h2/h4 and h_valid inputs.

Verification
REQ-029 h_i=0x8000...0 (unity), h_load -> h1=h2=h4=0x8000...0, h_valid=1 exactly at T+257.
REQ-030 h_i=0x4000...0 (x) -> h2=0x2000...0, h4=0x0800...0; with H3_EN h3=0x1000...0, h_valid at T+385.
REQ-031 h_i=0x00000000_80000000_00000000_00000000 (x^32) -> h2=0x00000000_00000000_80000000_00000000, h4=0xE1000000_00000000_00000000_00000000 (reduction check).
REQ-032 h_i=0 -> all outputs 0, h_valid=1 at T+257; busy high T+1..T+256 only.
REQ-033 Load x^32, second h_load with unity at T+100 -> h_valid stays 0 until T+357, then unity outputs; no intermediate valid.
REQ-034 rst asserted at T+150 mid-SQ4 -> next cycle all outputs 0, busy=0, h_valid=0; fresh h_load then completes normally.
